// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake and divide-by-zero detection.
module seq_div #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q;
    logic [N-1:0]   rem_q;
    logic [N-1:0]   quo_q;
    logic [N-1:0]   dsr_q;
    logic [CW-1:0]  cnt_q;

    logic [N:0]     trial;
    logic           less;
    logic [N-1:0]   diff;
    logic [N-1:0]   rem_nxt;
    logic [N-1:0]   quo_nxt;

    // The working remainder always stays below the divisor, so N bits hold it;
    // only the trial value and the comparison need the extra bit.
    always_comb begin
        trial   = {rem_q, quo_q[N-1]};
        less    = trial < {1'b0, dsr_q};
        diff    = trial[N-1:0] - dsr_q;
        rem_nxt = less ? trial[N-1:0] : diff;
        quo_nxt = {quo_q[N-2:0], ~less};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state_q     <= StDone;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_q     <= StRun;
                            busy        <= 1'b1;
                            cnt_q       <= '0;
                            rem_q       <= '0;
                            quo_q       <= dividend;
                            dsr_q       <= divisor;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_nxt;
                        remainder <= rem_nxt;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed and random self-checking bench for seq_div (N=8).
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seq_div #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from IDLE and check latency, busy span, result and pulse width.
    // With poke set, a second request is raised mid-run and must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
        logic [7:0] eq, er, pq, pr;
        int         lat, bz, exp_lat;
        bit         dbz, stable;
        dbz     = (b == 8'd0);
        eq      = dbz ? 8'hff : a / b;
        er      = dbz ? a : a % b;
        exp_lat = dbz ? 0 : 8;
        pq      = quotient;
        pr      = remainder;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat    = 0;
        bz     = 0;
        stable = 1'b1;
        while (!done && lat < 20) begin
            if (busy) bz++;
            if (quotient !== pq || remainder !== pr) stable = 1'b0;
            if (poke && lat == 2) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_cycles", bz, exp_lat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, dbz);
        check("hold_during_run", stable, 1);
        if (!dbz) check("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        check("busy_with_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int  t_first, t_second, waited;
        bit  seen;
        logic [7:0] ra, rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        run_op(8'd200, 8'd7, 1'b0);
        run_op(8'd255, 8'd1, 1'b0);
        run_op(8'd5, 8'd9, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd0, 8'd3, 1'b0);
        run_op(8'd100, 8'd0, 1'b0);
        run_op(8'd100, 8'd10, 1'b0);
        run_op(8'd200, 8'd7, 1'b1);

        // Start held high: results must come back every 10 cycles.
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd10;
        t_first  = -1;
        t_second = -1;
        waited   = 0;
        while (t_second < 0 && waited < 40) begin
            tick();
            waited++;
            if (done) begin
                if (t_first < 0) t_first = cyc;
                else t_second = cyc;
            end
        end
        start = 1'b0;
        check("b2b_seen", (t_second >= 0), 1);
        check("b2b_period", t_second - t_first, 10);
        check("b2b_quotient", quotient, 10);
        tick();

        // Reset asserted during the 4th RUN cycle aborts the operation.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        run_op(8'd9, 8'd2, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
